// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, request op codes, HI/LO source-mux selects.
package muldiv_pkg;

  // 3-bit state encoding shared by the sequencer and anything that probes it.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_EXC   = 3'd5
  } state_t;

  // Request op codes as presented by the control unit.
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // HI/LO source-mux selects.
  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  // Maps a latched op onto the HI/LO mux select for that op's result unit.
  function automatic logic op_to_sel(input logic op);
    return (op == OP_DIV) ? SEL_DIV : SEL_MULT;
  endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter: loadable down-counter timing the Mult/Div iterations.
// Latency: load/decrement visible the cycle after the edge; zero flag is combinational from the count.
// Backpressure: none; en holds the count when low.
// Ports: clk, reset (sync, active-high), load + load_val, en (decrement), zero (count == 0).
module muldiv_cycle_counter
  import muldiv_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; the count saturates at zero so a stray enable
  // after expiry cannot wrap it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs one MULT/DIV at a time on the shared Mult/Div units and drives HI/LO writes.
// Latency: start pulse 1 cycle after accept, HI/LO write at N+2, done at N+3, ready again at N+4 (N = unit iterations);
// Backpressure: req_ready only in IDLE, requests while busy are ignored (requester holds req_valid).
// Ports: req_valid/req_op/b_operand from control, flush abort; mult_start/div_start to the units;
//        hi_sel/lo_sel/hi_write/lo_write to HI/LO; busy/done/div_zero_exc status.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] b_operand,
  input  logic        flush,
  output logic        req_ready,
  output logic        mult_start,
  output logic        div_start,
  output logic        hi_sel,
  output logic        lo_sel,
  output logic        hi_write,
  output logic        lo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc
);

  // RUN is entered with the count at N-1 and left on the cycle it reads 0,
  // which makes RUN exactly N cycles long.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             op_q;
  logic             op_nxt;
  logic             write_q;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  // Next-state and op-latch decision. flush forces IDLE from anywhere, which
  // also blocks acceptance while idle.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_nxt = req_op;
            // A zero divisor never starts the divider; it becomes an exception.
            if ((req_op == OP_DIV) && (b_operand == 32'd0)) begin
              state_nxt = ST_EXC;
            end else begin
              state_nxt = ST_START;
            end
          end
        end
        ST_START: state_nxt = ST_RUN;
        ST_RUN:   if (cnt_zero) state_nxt = ST_WRITE;
        ST_WRITE: state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        ST_EXC:   state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // The counter is only armed from START; a flush in START leaves it alone.
  assign cnt_load     = (state == ST_START) && !flush;
  assign cnt_en       = (state == ST_RUN) && !flush;
  assign cnt_load_val = (op_q == OP_DIV) ? DIV_LOAD : MULT_LOAD;

  muldiv_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // State, op latch and state-decoded outputs. Outputs are decoded from the
  // next state so the registered copies line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= OP_MULT;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      write_q      <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
    end else begin
      state        <= state_nxt;
      op_q         <= op_nxt;
      req_ready    <= (state_nxt == ST_IDLE);
      busy         <= (state_nxt != ST_IDLE);
      mult_start   <= (state_nxt == ST_START) && (op_nxt == OP_MULT);
      div_start    <= (state_nxt == ST_START) && (op_nxt == OP_DIV);
      write_q      <= (state_nxt == ST_WRITE);
      done         <= (state_nxt == ST_DONE);
      div_zero_exc <= (state_nxt == ST_EXC);
    end
  end

  // Selects follow the latched op in every state, so they are steady from
  // START through DONE.
  assign hi_sel = op_to_sel(op_q);
  assign lo_sel = op_to_sel(op_q);

  // A flush arriving in WRITE must stop the HI/LO update in that same cycle.
  assign hi_write = write_q && !flush;
  assign lo_write = write_q && !flush;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer.
// The driver schedules expected pulses (by absolute cycle) into a queue from a
// timeline model; the monitor pops due entries each cycle and compares.
module tb_muldiv_sequencer;

  localparam int MC = 5;
  localparam int DC = 11;
  localparam int CW = 4;

  // Pulse vector bit order: {exc, done, lo_write, hi_write, div_start, mult_start}
  localparam logic [5:0] P_MSTART = 6'b000001;
  localparam logic [5:0] P_DSTART = 6'b000010;
  localparam logic [5:0] P_WRITE  = 6'b001100;
  localparam logic [5:0] P_DONE   = 6'b010000;
  localparam logic [5:0] P_EXC    = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [31:0] b_operand = 32'd0;
  logic        flush = 1'b0;
  logic        req_ready, mult_start, div_start, hi_sel, lo_sel;
  logic        hi_write, lo_write, busy, done, div_zero_exc;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .b_operand    (b_operand),
    .flush        (flush),
    .req_ready    (req_ready),
    .mult_start   (mult_start),
    .div_start    (div_start),
    .hi_sel       (hi_sel),
    .lo_sel       (lo_sel),
    .hi_write     (hi_write),
    .lo_write     (lo_write),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc)
  );

  typedef struct packed {
    int         cyc;
    logic [5:0] pulses;
  } ev_t;

  ev_t evq[$];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Timeline model: the sequencer is free from cycle idle_at onward.
  int   idle_at = 0;
  int   known_from = 32'h3fff_ffff;
  int   acc_cyc = -1;
  logic exp_ready = 1'b1;
  logic exp_sel = 1'b0;
  logic pend_sel = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(input int c, input logic [5:0] p);
    ev_t e;
    e.cyc = c;
    e.pulses = p;
    evq.push_back(e);
  endfunction

  // Drop everything scheduled after cycle c; a flush also kills a write due in c.
  function automatic void cancel_after(input int c, input logic is_flush);
    ev_t e;
    while (evq.size() > 0 && evq[evq.size()-1].cyc > c) void'(evq.pop_back());
    if (is_flush && evq.size() > 0 && evq[evq.size()-1].cyc == c) begin
      e = evq.pop_back();
      e.pulses = e.pulses & ~P_WRITE;
      if (e.pulses != 6'b0) evq.push_back(e);
    end
  endfunction

  // Drive one cycle's inputs and advance the timeline model.
  task automatic step(input logic rv, input logic op, input logic [31:0] b,
                      input logic fl, input logic rst);
    int n;
    @(posedge clk);
    #1;
    req_valid = rv;
    req_op    = op;
    b_operand = b;
    flush     = fl;
    reset     = rst;
    exp_sel   = pend_sel;
    exp_ready = (cyc >= idle_at);
    if (rst) begin
      cancel_after(cyc, 1'b0);
      idle_at  = cyc + 1;
      pend_sel = 1'b0;
      if (known_from > cyc + 1) known_from = cyc + 1;
    end else if (fl) begin
      cancel_after(cyc, 1'b1);
      if (idle_at > cyc + 1) idle_at = cyc + 1;
    end else if (exp_ready && rv) begin
      acc_cyc  = cyc;
      pend_sel = op;
      if (op && (b == 32'd0)) begin
        push_ev(cyc + 1, P_EXC);
        idle_at = cyc + 2;
      end else begin
        n = op ? DC : MC;
        push_ev(cyc + 1, op ? P_DSTART : P_MSTART);
        push_ev(cyc + n + 2, P_WRITE);
        push_ev(cyc + n + 3, P_DONE);
        idle_at = cyc + n + 4;
      end
    end
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Hold a request until the model accepts it; optionally flush or reset
  // `off` cycles after the accept; then idle until the sequencer is free again.
  task automatic do_op(input logic op, input logic [31:0] b, input int off, input logic use_rst);
    int prev;
    int guard;
    prev = acc_cyc;
    guard = 0;
    while (acc_cyc == prev && guard < 200) begin
      step(1'b1, op, b, 1'b0, 1'b0);
      guard++;
    end
    if (off > 0) begin
      idle_steps(off - 1);
      step(1'b0, 1'b0, 32'd0, !use_rst, use_rst);
    end
    guard = 0;
    while (cyc < idle_at && guard < 200) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  // Monitor: compares levels every cycle and pulses whenever any is due or seen.
  logic [5:0] mon_exp;
  logic [5:0] mon_act;
  logic [3:0] lvl_exp;
  logic [3:0] lvl_act;

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= known_from) begin
        mon_exp = 6'b0;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
          mon_exp = mon_exp | evq[0].pulses;
          void'(evq.pop_front());
        end
        mon_act = {div_zero_exc, done, lo_write, hi_write, div_start, mult_start};
        if (mon_act != 6'b0 || mon_exp != 6'b0) begin
          total++;
          if (mon_act !== mon_exp) begin
            bad++;
            $display("FAIL pulses cyc=%0d got=%b want=%b (exc,done,lo_w,hi_w,dstart,mstart)",
                     cyc, mon_act, mon_exp);
          end
        end
        lvl_exp = {exp_ready, !exp_ready, exp_sel, exp_sel};
        lvl_act = {req_ready, busy, hi_sel, lo_sel};
        total++;
        if (lvl_act !== lvl_exp) begin
          bad++;
          $display("FAIL levels cyc=%0d got=%b want=%b (ready,busy,hi_sel,lo_sel)",
                   cyc, lvl_act, lvl_exp);
        end
      end
    end
  end

  initial begin
    int r;
    logic [31:0] b;
    logic op;

    // Reset, then plain operations.
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    idle_steps(2);
    do_op(1'b0, 32'd5, 0, 1'b0);          // MULT
    do_op(1'b1, 32'd7, 0, 1'b0);          // DIV
    do_op(1'b1, 32'd0, 0, 1'b0);          // DIV by zero
    do_op(1'b0, 32'd0, 0, 1'b0);          // MULT with zero operand is normal
    // Flush in each phase.
    do_op(1'b1, 32'd9, 10, 1'b0);         // RUN
    do_op(1'b0, 32'd1, 1, 1'b0);          // START
    do_op(1'b0, 32'd1, MC + 2, 1'b0);     // WRITE
    do_op(1'b1, 32'd2, DC + 3, 1'b0);     // DONE
    do_op(1'b1, 32'd0, 1, 1'b0);          // EXC
    // Flush while idle blocks a pending request.
    step(1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'd5, 1'b1, 1'b0);
    idle_steps(2);
    // Request held through a whole MULT with op toggling.
    for (int i = 0; i < 2 * (MC + 4) + 3; i++) step(1'b1, (i / 3) % 2 == 1, 32'd4, 1'b0, 1'b0);
    do_op(1'b0, 32'd1, 0, 1'b0);
    // Reset mid-RUN, then a clean op.
    do_op(1'b1, 32'd3, 4, 1'b1);
    do_op(1'b0, 32'd3, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      op = $urandom_range(0, 1) == 1;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(r < 60, op, b, (r >= 60 && r < 63), (r == 99));
    end

    // Drain and make sure nothing scheduled was left unseen.
    for (int i = 0; i < 40 && cyc < idle_at + 2; i++) idle_steps(1);
    idle_steps(2);
    @(negedge clk);
    #1;
    total++;
    if (evq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", evq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequences the shared multiplier/divider resource of the multicycle CPU: accepts one MULT/DIV request at a time from the control unit, pulses the selected unit's start, counts its fixed iteration latency, then drives the HI/LO source-mux selects and write enables. It also raises a one-cycle divide-by-zero exception instead of starting the divider. It sits between the control unit and the Mult, Div, HI, LO and HI/LO source-mux instances.

## Interface
Parameters:
- MULT_CYCLES, 32, multiplier iterations after its start pulse before HI/LO are valid (≥1)
- DIV_CYCLES, 32, divider iterations after its start pulse before HI/LO are valid (≥1)
- CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)−1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  control unit requests an operation
- req_op  in  1  0 = MULT, 1 = DIV
- b_operand  in  32  current B register value; used only for the zero check at accept
- flush  in  1  abort any operation in progress (exception/restart)
- req_ready  out  1  sequencer is idle and can accept
- mult_start  out  1  one-cycle start pulse to Mult
- div_start  out  1  one-cycle start pulse to Div
- hi_sel  out  1  HI source-mux select (0 = Mult, 1 = Div)
- lo_sel  out  1  LO source-mux select (0 = Mult, 1 = Div)
- hi_write  out  1  HI register write enable
- lo_write  out  1  LO register write enable
- busy  out  1  operation in progress (every state except IDLE)
- done  out  1  one-cycle completion pulse
- div_zero_exc  out  1  one-cycle divide-by-zero exception pulse

## Operation
- States: IDLE, START, RUN, WRITE, DONE, EXC. Registered op bit `op_q` and down-counter `cnt`.
- IDLE: req_ready=1. On req_valid & ~flush, the request is accepted and `op_q`←req_op.
  - DIV with b_operand==0 → EXC.
  - Otherwise → START.
- START: mult_start = ~op_q, div_start = op_q. Loads `cnt` with (op_q ? DIV_CYCLES : MULT_CYCLES)−1. → RUN.
- RUN: decrement `cnt`. Leave for WRITE when `cnt`==0, so RUN lasts exactly MULT_CYCLES or DIV_CYCLES cycles.
- WRITE: hi_write = lo_write = ~flush. → DONE.
- DONE: done=1. → IDLE.
- EXC: div_zero_exc=1. No start pulse, no write. → IDLE.
- hi_sel = lo_sel = `op_q` in all states. The selects are stable from START through DONE.
- Outputs are decoded from the state, except hi_write/lo_write, which are also gated by flush.
- flush: from any state, next state is IDLE and `cnt` is not loaded. flush during IDLE blocks acceptance. flush during WRITE suppresses both write enables in that cycle. flush does not suppress done or div_zero_exc already being driven that cycle.
- req_valid while busy is ignored; no queuing. The requester holds req_valid until it sees req_ready.
- Reset: state IDLE, `op_q`=0, `cnt`=0. req_ready=1. All other outputs 0. reset overrides flush and req_valid.
- Start pulses are exactly one cycle and never overlap. At most one of mult_start/div_start is asserted per accepted request.

## Timing
- Accept cycle = cycle 0 (IDLE, req_valid=1). START = cycle 1. RUN = cycles 2 … N+1, where N = MULT_CYCLES or DIV_CYCLES. WRITE = cycle N+2. DONE = cycle N+3. IDLE (req_ready=1) = cycle N+4.
- Defaults: start pulse at cycle 1, HI/LO written at the edge ending cycle 34, done at cycle 35, next accept possible at cycle 36.
- Divide-by-zero: div_zero_exc at cycle 1, req_ready=1 again at cycle 2.
- flush asserted in cycle k: IDLE (req_ready=1) in cycle k+1.

## Structure
- Shared package/include `muldiv_pkg`:
  - state encoding (3-bit): IDLE, START, RUN, WRITE, DONE, EXC
  - op constants: OP_MULT=1'b0, OP_DIV=1'b1
  - mux-select constants: SEL_MULT=0, SEL_DIV=1
- One natural sub-module, `muldiv_cycle_counter`: loadable CNT_W down-counter with load, enable and zero flag. The FSM and output decode live in the top.

## Test plan
- MULT, defaults: accept at cycle 0 → mult_start only at cycle 1; hi_write=lo_write=1 and hi_sel=lo_sel=0 at cycle 34; done at cycle 35; req_ready at 36. div_start never asserted.
- DIV, b_operand=7: div_start at cycle 1; writes with selects=1 at cycle 34; done at cycle 35. mult_start never asserted.
- DIV, b_operand=0: div_zero_exc=1 at cycle 1; no start pulse, no hi_write/lo_write, no done; req_ready=1 at cycle 2.
- flush in RUN at cycle 10: IDLE at cycle 11; no write or done follows. flush during WRITE: writes stay 0 that cycle.
- req_valid held high through a whole MULT, with req_op toggled mid-run: exactly one operation completes. The second request is accepted at cycle 36 with the op presented at that cycle.
- reset asserted mid-RUN: next cycle req_ready=1 and all other outputs 0. A MULT with MULT_CYCLES=3 completes with done at cycle 6.
